alu_mult_seq: RTL and testbench
===============================

Name: alu_mult_seq

Overview:
Sequential 32x32 unsigned shift-and-add multiplier. It does not contain an adder; it is the initiator of the existing combinational ALU interface. Each cycle it drives command/operandA/operandB to an external ALU instance and consumes result/carryout. It sits beside the ALU in the datapath and gives the design a multiply without a second adder.

Parameters:
WIDTH, 32, operand width; must equal the ALU width (only 32 is supported)
CNT_W, 6, iteration counter width; holds 0..WIDTH

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE
req_a  in  WIDTH  multiplicand
req_b  in  WIDTH  multiplier
resp_valid  out  1  product available; held until accepted
resp_ready  in  1  consumer accepts the product
resp_product  out  2*WIDTH  unsigned product {hi,lo}
resp_zero  out  1  product == 0
resp_overflow  out  1  hi half != 0 (product does not fit in WIDTH)
alu_command  out  3  to ALU command; constant opADD (3'd0)
alu_operandA  out  WIDTH  to ALU operandA
alu_operandB  out  WIDTH  to ALU operandB
alu_result  in  WIDTH  from ALU result
alu_carryout  in  1  from ALU carryout

Behaviour:
- Reset: clk and reset as named above; reset is synchronous and active-high, checked at the rising edge and wins over everything. After reset: state=IDLE, req_ready=1, resp_valid=0, resp_product=0, resp_zero=0, resp_overflow=0, counter=0, alu_operandA=0, alu_operandB=0, alu_command=3'd0.
- Registers: MC (multiplicand, WIDTH), P (partial hi, WIDTH), M (multiplier/lo, WIDTH), cnt (CNT_W).
- IDLE: on an edge with req_valid=1: MC<=req_a, P<=0, M<=req_b, cnt<=0, go to COMPUTE. req_ready is combinational from state (IDLE only).
- COMPUTE: alu_operandA=P and alu_operandB = M[0] ? MC : 0 (combinational from registers). alu_command=opADD. Each edge: {P,M} <= {alu_carryout, alu_result, M} >> 1, cnt<=cnt+1. When cnt==WIDTH-1, also latch resp_product<={next P,next M}, set resp_zero and resp_overflow from that value, and go to DONE.
- ALU path: the ALU is combinational. The path register -> ALU -> register must close within one cycle; no waiting for ALU settle is needed.
- DONE: resp_valid=1. resp_product and the flags are stable until accepted. alu_operandA and alu_operandB are 0. On an edge with resp_ready=1, go to IDLE. resp_valid drops and req_ready rises in the same cycle.
- Latency: request accepted at edge E0; resp_valid is high after edge E0+WIDTH (32 cycles). Throughput is one product per WIDTH+2 cycles minimum.
- req_valid outside IDLE: ignored. Inputs are not sampled, and no queueing occurs.
- resp_ready while not DONE: ignored.
- req_a/req_b are sampled only at acceptance. Later changes have no effect.
- Reset mid-COMPUTE or in DONE: the operation is abandoned and all outputs return to reset values. No response is produced.
- Carry: alu_carryout is the 33rd bit of the partial sum and shifts into P[WIDTH-1]. It must never be dropped.
- ALU overflow/zero outputs are not used.
- Unused state encoding: go to IDLE.

Decomposition:
- Shared include (alu_defs): the opADD/opSUB/opXOR/opSLT/opCNE 3-bit encodings, used by the ALU and this block alike. State encodings IDLE=2'd0, COMPUTE=2'd1, DONE=2'd2.
- No sub-module inside this block. The bench and the top level instantiate the existing ALU and connect it to the alu_* ports.

Test Plan:
- 3 x 5, resp_ready=1 -> resp_valid exactly 32 cycles after acceptance; product 0x0000_0000_0000_000F; zero=0; overflow=0. alu_command is 0 throughout.
- 0xFFFFFFFF x 0xFFFFFFFF -> product 0xFFFF_FFFE_0000_0001; overflow=1. This exercises alu_carryout on every iteration.
- 0 x 0x12345678 -> product 0; zero=1; overflow=0. Also 0x00010000 x 0x00010000 -> 0x0000_0001_0000_0000; overflow=1.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE with req_valid=1 pulsed and req_a changing -> product unchanged and req_ready=0. The new request is accepted only after the resp_ready handshake and the return to IDLE.
- Reset asserted at COMPUTE cycle 15 -> next cycle IDLE, all outputs 0. A following 7 x 6 returns 42 with full latency.
- Back-to-back: 10 random pairs with random resp_ready gaps, checked against a 64-bit reference model. req_ready and resp_valid are never high together.

Source files
------------

// File: rtl/alu_mult_seq_pkg.sv
// Shared ALU command encodings and multiplier FSM states.
package alu_mult_seq_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_SLT = 3'd3;
    localparam logic [2:0] OP_CNE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;
endpackage

// File: rtl/alu_mult_seq.sv
// Sequential shift-and-add multiplier that borrows an external combinational ALU
// for its single add per iteration.
module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2*WIDTH-1:0]   resp_product,
    output logic                 resp_zero,
    output logic                 resp_overflow,
    output logic [2:0]           alu_command,
    output logic [WIDTH-1:0]     alu_operandA,
    output logic [WIDTH-1:0]     alu_operandB,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_carryout
);
    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mc_q, mc_d, p_q, p_d, m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 zero_q, zero_d, ovf_q, ovf_d;
    logic                 last_iter;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:    state_d = req_valid  ? ST_COMPUTE : ST_IDLE;
            ST_COMPUTE: state_d = last_iter  ? ST_DONE    : ST_COMPUTE;
            ST_DONE:    state_d = resp_ready ? ST_IDLE    : ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mc_d   = mc_q;
        p_d    = p_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    mc_d  = req_a;
                    p_d   = '0;
                    m_d   = req_b;
                    cnt_d = '0;
                end
            end
            ST_COMPUTE: begin
                // The carry becomes the new MSB of P; the consumed multiplier bit falls off.
                {p_d, m_d} = {alu_carryout, alu_result, m_q[WIDTH-1:1]};
                cnt_d      = cnt_q + 1'b1;
                if (last_iter) begin
                    prod_d = {p_d, m_d};
                    zero_d = ({p_d, m_d} == '0);
                    ovf_d  = (p_d != '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mc_q   <= '0;
            p_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            mc_q   <= mc_d;
            p_q    <= p_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        req_ready    = (state_q == ST_IDLE);
        resp_valid   = (state_q == ST_DONE);
        alu_command  = OP_ADD;
        alu_operandA = '0;
        alu_operandB = '0;
        if (state_q == ST_COMPUTE) begin
            alu_operandA = p_q;
            alu_operandB = m_q[0] ? mc_q : '0;
        end
    end

    assign resp_product  = prod_q;
    assign resp_zero     = zero_q;
    assign resp_overflow = ovf_q;
endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq with a behavioural ALU adder and a 64-bit multiply reference.
module tb_alu_mult_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_product;
    logic        resp_zero, resp_overflow;
    logic [2:0]  alu_command;
    logic [31:0] alu_operandA, alu_operandB, alu_result;
    logic        alu_carryout;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared combinational ALU: only ADD matters here.
    assign {alu_carryout, alu_result} = (alu_command == 3'd0)
        ? ({1'b0, alu_operandA} + {1'b0, alu_operandB}) : 33'd0;

    alu_mult_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_product(resp_product), .resp_zero(resp_zero), .resp_overflow(resp_overflow),
        .alu_command(alu_command), .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
        .alu_result(alu_result), .alu_carryout(alu_carryout)
    );

    always @(negedge clk) begin
        if (req_ready && resp_valid) viol++;
        if (alu_command != 3'd0) viol++;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        logic        zero;
        logic        ovf;
        int          gap;
        bit          pulse;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input logic ez, input logic eo,
                          input int gap, input bit pulse);
        int cyc;
        chk("req_ready_before", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_a = a; req_b = b;
        tick();
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
        cyc = 0;
        while (!resp_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("latency", 64'(cyc), 64'd32);
        chk("product", resp_product, exp);
        chk("zero", {63'd0, resp_zero}, {63'd0, ez});
        chk("overflow", {63'd0, resp_overflow}, {63'd0, eo});
        for (int i = 0; i < gap; i++) begin
            if (pulse) begin
                req_valid = 1'b1; req_a = $urandom; req_b = $urandom;
            end
            tick();
            chk("hold_product", resp_product, exp);
            chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
            chk("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk("resp_valid_drop", {63'd0, resp_valid}, 64'd0);
        chk("req_ready_rise", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [63:0] rp;
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_a = '0; req_b = '0;

        vecs[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1, 0, 1'b0};
        vecs[2] = '{32'd0, 32'h1234_5678, 64'd0, 1'b1, 1'b0, 0, 1'b0};
        vecs[3] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b1, 0, 1'b0};
        vecs[4] = '{32'hDEAD_BEEF, 32'd2, 64'h0000_0001_BD5B_7DDE, 1'b0, 1'b1, 10, 1'b1};
        vecs[5] = '{32'd1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b1, 2, 1'b0};

        tick(); tick();
        reset = 1'b0;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_product", resp_product, 64'd0);
        chk("rst_flags", {62'd0, resp_zero, resp_overflow}, 64'd0);
        chk("rst_operands", {alu_operandA, alu_operandB}, 64'd0);
        chk("rst_command", {61'd0, alu_command}, 64'd0);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].zero, vecs[i].ovf,
                   vecs[i].gap, vecs[i].pulse);

        // Abandon an operation partway through COMPUTE.
        req_valid = 1'b1; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        repeat (15) tick();
        chk("mid_busy", {63'd0, req_ready}, 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("mid_rst_product", resp_product, 64'd0);
        chk("mid_rst_flags", {62'd0, resp_zero, resp_overflow}, 64'd0);
        chk("mid_rst_operands", {alu_operandA, alu_operandB}, 64'd0);
        run_op(32'd7, 32'd6, 64'd42, 1'b0, 1'b0, 0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            ra = $urandom;
            rb = (n == 3) ? 32'd0 : $urandom;
            rp = ref_mul(ra, rb);
            run_op(ra, rb, rp, rp == 64'd0, rp[63:32] != 32'd0,
                   int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)));
        end

        chk("never_both_or_bad_cmd", 64'(viol), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
